// File: rtl/shadow_round_core_if.sv
//==============================================================================
// Module      : shadow_round_core_if
// Description : Block-in / block-out / round-key bus of shadow_round_core.
//               abort_i exists only when SHADOW_CORE_ABORT_EN is defined.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface shadow_round_core_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             mode_i;
    logic [WIDTH-1:0] l_i;
    logic [WIDTH-1:0] r_i;
    logic             rk_req;
    logic [IDX_W-1:0] rk_idx;
    logic [WIDTH-1:0] rk_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] l_o;
    logic [WIDTH-1:0] r_o;
`ifdef SHADOW_CORE_ABORT_EN
    logic             abort_i;

    modport master (
        output in_valid, mode_i, l_i, r_i, rk_i, out_ready, abort_i,
        input  in_ready, rk_req, rk_idx, out_valid, l_o, r_o
    );
    modport slave (
        input  in_valid, mode_i, l_i, r_i, rk_i, out_ready, abort_i,
        output in_ready, rk_req, rk_idx, out_valid, l_o, r_o
    );
`else
    modport master (
        output in_valid, mode_i, l_i, r_i, rk_i, out_ready,
        input  in_ready, rk_req, rk_idx, out_valid, l_o, r_o
    );
    modport slave (
        input  in_valid, mode_i, l_i, r_i, rk_i, out_ready,
        output in_ready, rk_req, rk_idx, out_valid, l_o, r_o
    );
`endif
endinterface

`default_nettype wire

// File: rtl/shadow_round_core.sv
//==============================================================================
// Module      : shadow_round_core
// Description : Iterative Shadow/Simon-style Feistel engine, one round per
//               clock, encrypt or decrypt. Optional abort via macro
//               SHADOW_CORE_ABORT_EN.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module shadow_round_core #(
    parameter int WIDTH  = 8,
    parameter int ROUNDS = 32,
    parameter int ROT_A  = 1,
    parameter int ROT_B  = 7,
    parameter int ROT_C  = 2
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    shadow_round_core_if.slave  bus
);
    localparam int IDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_BUSY = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(ROUNDS - 1);

    function automatic logic [WIDTH-1:0] rol(input logic [WIDTH-1:0] x, input int n);
        return (x << n) | (x >> (WIDTH - n));
    endfunction

    function automatic logic [WIDTH-1:0] f_fn(input logic [WIDTH-1:0] x);
        return (rol(x, ROT_A) & rol(x, ROT_B)) ^ rol(x, ROT_C);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] l_q, l_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            C_IDLE: begin
                if (bus.in_valid) begin
                    l_d     = bus.l_i;
                    r_d     = bus.r_i;
                    mode_d  = bus.mode_i;
                    cnt_d   = '0;
                    state_d = C_BUSY;
                end
            end
            C_BUSY: begin
                // Decrypt is the exact inverse: the roles of the halves swap.
                if (!mode_q) begin
                    l_d = r_q ^ f_fn(l_q) ^ bus.rk_i;
                    r_d = l_q;
                end else begin
                    l_d = r_q;
                    r_d = l_q ^ f_fn(r_q) ^ bus.rk_i;
                end
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == C_LAST_IDX) begin
                    state_d = C_DONE;
                end
            end
            C_DONE: begin
                if (bus.out_ready) begin
                    state_d = C_IDLE;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
`ifdef SHADOW_CORE_ABORT_EN
        if (bus.abort_i && (state_q != C_IDLE)) begin
            state_d = C_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == C_IDLE);
    assign bus.out_valid = (state_q == C_DONE);
    assign bus.rk_req    = (state_q == C_BUSY);
    assign bus.rk_idx    = (state_q != C_BUSY) ? '0 :
                           (mode_q ? (C_LAST_IDX - cnt_q) : cnt_q);
    assign bus.l_o       = l_q;
    assign bus.r_o       = r_q;

endmodule

`default_nettype wire

// File: tb/tb_shadow_round_core.sv
//==============================================================================
// Module      : tb_shadow_round_core
// Description : Directed bench for shadow_round_core (8-bit/1-round and
//               16-bit/8-round instances); optional abort under
//               SHADOW_CORE_ABORT_EN.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module tb_shadow_round_core;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    shadow_round_core_if #(.WIDTH(8),  .IDX_W(1)) if8  ();
    shadow_round_core_if #(.WIDTH(16), .IDX_W(3)) if16 ();

    shadow_round_core #(.WIDTH(8), .ROUNDS(1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    shadow_round_core #(.WIDTH(16), .ROUNDS(8)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    // Key ROM for the 16-bit instance: k[i] = 0x1111 * i.
    assign if16.rk_i = 16'(if16.rk_idx) * 16'h1111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] f16(input logic [15:0] x);
        logic [15:0] y;
        for (int b = 0; b < 16; b++) begin
            y[b] = (x[(b + 15) % 16] & x[(b + 9) % 16]) ^ x[(b + 14) % 16];
        end
        return y;
    endfunction

    function automatic logic [31:0] enc16(input logic [15:0] l, input logic [15:0] r);
        logic [15:0] nl;
        for (int i = 0; i < 8; i++) begin
            nl = r ^ f16(l) ^ 16'(i * 16'h1111);
            r  = l;
            l  = nl;
        end
        return {l, r};
    endfunction

    task automatic run8(input string tag, input logic m, input logic [7:0] l, input logic [7:0] r,
                        input logic [7:0] k, input logic [7:0] el, input logic [7:0] er);
        if8.in_valid = 1'b1;
        if8.mode_i   = m;
        if8.l_i      = l;
        if8.r_i      = r;
        if8.rk_i     = k;
        @(negedge clk);
        if8.in_valid = 1'b0;
        if8.mode_i   = ~m;
        chk({tag, " rk_req"},      32'(if8.rk_req),    32'd1);
        chk({tag, " busy_nvalid"}, 32'(if8.out_valid), 32'd0);
        @(negedge clk);
        chk({tag, " out_valid"},   32'(if8.out_valid), 32'd1);
        chk({tag, " l_o"},         32'(if8.l_o),       32'(el));
        chk({tag, " r_o"},         32'(if8.r_o),       32'(er));
        if8.out_ready = 1'b1;
        @(negedge clk);
        if8.out_ready = 1'b0;
        chk({tag, " back_idle"},   32'(if8.in_ready),  32'd1);
    endtask

    // Accepts one block and follows it into DONE; leaves the result unconsumed.
    task automatic run16(input string tag, input logic m, input logic [15:0] l, input logic [15:0] r,
                         input logic [15:0] el, input logic [15:0] er);
        if16.in_valid = 1'b1;
        if16.mode_i   = m;
        if16.l_i      = l;
        if16.r_i      = r;
        @(negedge clk);
        if16.in_valid = 1'b0;
        if16.mode_i   = ~m;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("%s rk_idx%0d", tag, c), 32'(if16.rk_idx), m ? 32'(7 - c) : 32'(c));
            chk($sformatf("%s rk_req%0d", tag, c), 32'(if16.rk_req), 32'd1);
            chk($sformatf("%s early%0d",  tag, c), 32'(if16.out_valid), 32'd0);
            @(negedge clk);
        end
        chk({tag, " out_valid"}, 32'(if16.out_valid), 32'd1);
        chk({tag, " l_o"},       32'(if16.l_o),       32'(el));
        chk({tag, " r_o"},       32'(if16.r_o),       32'(er));
    endtask

    task automatic release16(input string tag);
        if16.out_ready = 1'b1;
        @(negedge clk);
        if16.out_ready = 1'b0;
        chk({tag, " back_idle"}, 32'(if16.in_ready), 32'd1);
    endtask

    logic [31:0] ct;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        {if8.in_valid, if8.mode_i, if8.l_i, if8.r_i, if8.rk_i, if8.out_ready} = '0;
        {if16.in_valid, if16.mode_i, if16.l_i, if16.r_i, if16.out_ready} = '0;
`ifdef SHADOW_CORE_ABORT_EN
        if8.abort_i  = 1'b0;
        if16.abort_i = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst in_ready",  32'(if16.in_ready),  32'd1);
        chk("rst out_valid", 32'(if16.out_valid), 32'd0);
        chk("rst rk_req",    32'(if16.rk_req),    32'd0);
        chk("rst rk_idx",    32'(if16.rk_idx),    32'd0);
        chk("rst l_o",       32'(if16.l_o),       32'd0);
        chk("rst r_o",       32'(if16.r_o),       32'd0);
        chk("rst in_ready8", 32'(if8.in_ready),   32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        run8("e8a", 1'b0, 8'h01, 8'h00, 8'h00, 8'h04, 8'h01);
        run8("e8b", 1'b0, 8'hFF, 8'h5A, 8'h3C, 8'h66, 8'hFF);
        run8("d8",  1'b1, 8'h04, 8'h01, 8'h00, 8'h01, 8'h00);

        ct = enc16(16'h1234, 16'hABCD);
        run16("enc16", 1'b0, 16'h1234, 16'hABCD, ct[31:16], ct[15:0]);
        release16("enc16");
        run16("dec16", 1'b1, ct[31:16], ct[15:0], 16'h1234, 16'hABCD);

        // Stall in DONE with in_valid toggling: nothing may move.
        for (int i = 0; i < 5; i++) begin
            if16.in_valid = ~if16.in_valid;
            if16.l_i      = 16'hDEAD;
            if16.r_i      = 16'hBEEF;
            @(negedge clk);
            chk($sformatf("hold l_o%0d", i),      32'(if16.l_o),       32'h1234);
            chk($sformatf("hold r_o%0d", i),      32'(if16.r_o),       32'hABCD);
            chk($sformatf("hold in_ready%0d", i), 32'(if16.in_ready),  32'd0);
            chk($sformatf("hold valid%0d", i),    32'(if16.out_valid), 32'd1);
        end
        if16.in_valid  = 1'b1;
        if16.mode_i    = 1'b0;
        if16.l_i       = 16'h1234;
        if16.r_i       = 16'hABCD;
        if16.out_ready = 1'b1;
        @(negedge clk);
        if16.out_ready = 1'b0;
        chk("handoff in_ready",  32'(if16.in_ready),  32'd1);
        chk("handoff out_valid", 32'(if16.out_valid), 32'd0);
        @(negedge clk);
        if16.in_valid = 1'b0;
        chk("next accept rk_req",   32'(if16.rk_req),   32'd1);
        chk("next accept in_ready", 32'(if16.in_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("round3 rk_idx", 32'(if16.rk_idx), 32'd3);

        rst_n = 1'b0;
        #1;
        chk("midrst in_ready",  32'(if16.in_ready),  32'd1);
        chk("midrst out_valid", 32'(if16.out_valid), 32'd0);
        chk("midrst rk_req",    32'(if16.rk_req),    32'd0);
        chk("midrst rk_idx",    32'(if16.rk_idx),    32'd0);
        chk("midrst l_o",       32'(if16.l_o),       32'd0);
        chk("midrst r_o",       32'(if16.r_o),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ct = enc16(16'hBEEF, 16'h0123);
        run16("post_rst", 1'b0, 16'hBEEF, 16'h0123, ct[31:16], ct[15:0]);
        release16("post_rst");

`ifdef SHADOW_CORE_ABORT_EN
        if16.in_valid = 1'b1;
        if16.mode_i   = 1'b0;
        @(negedge clk);
        if16.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        if16.abort_i = 1'b1;
        @(negedge clk);
        if16.abort_i = 1'b0;
        chk("abort in_ready",  32'(if16.in_ready),  32'd1);
        chk("abort out_valid", 32'(if16.out_valid), 32'd0);
        chk("abort rk_req",    32'(if16.rk_req),    32'd0);
        ct = enc16(16'h0F0F, 16'h5555);
        run16("post_abort", 1'b0, 16'h0F0F, 16'h5555, ct[31:16], ct[15:0]);
        release16("post_abort");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
